// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32x32 multiply / divide unit for the EX stage.
//   MULTU/MULT use a radix-2 shift-add, DIVU/DIV a restoring shift-subtract,
//   both on operand magnitudes with sign correction applied in a final cycle.
//   An accepted request produces its result 33 cycles later.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          mult/div instruction present in ID/EX
//   op             00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   dato_A/dato_B  operands (multiplicand/dividend, multiplier/divisor)
//   hi/lo          result registers (product high/low or remainder/quotient)
//   busy           operation in progress
//   done/div0      one-cycle result pulse / divide-by-zero flag
//   stall          combinational hold for the ID/EX register
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dato_A,
    input  logic [31:0] dato_B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic        stall
);

    localparam int unsigned W    = 32;
    localparam int unsigned CW   = 6;
    localparam int unsigned STEP = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            is_div_q, is_div_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            div0_q, div0_d;

    logic            accept;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_r;
    logic            div_ge;
    logic [W-1:0]    div_sub;
    logic [2*W-1:0]  div_next;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix, a_raw;

    // Requests are taken only in IDLE and never in the result cycle.
    assign accept = (state_q == IDLE) && start && !done_q;

    // Signed ops work on magnitudes; 0x80000000 stays 0x80000000 as unsigned.
    assign mag_a = (op[0] && dato_A[W-1]) ? (~dato_A + W'(1)) : dato_A;
    assign mag_b = (op[0] && dato_B[W-1]) ? (~dato_B + W'(1)) : dato_B;

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : (W+1)'(0));
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide step: acc = {partial remainder, dividend/quotient bits}.
    assign div_r    = acc_q[2*W-1:W-1];
    assign div_ge   = div_r >= {1'b0, b_q};
    assign div_sub  = W'(div_r - {1'b0, b_q});
    assign div_next = {(div_ge ? div_sub : div_r[W-1:0]), acc_q[W-2:0], div_ge};

    // Sign correction of the finished magnitude result.
    assign prod_fix = (sa_q ^ sb_q) ? (~acc_q + (2*W)'(1)) : acc_q;
    assign quo_fix  = (sa_q ^ sb_q) ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
    assign rem_fix  = sa_q ? (~acc_q[2*W-1:W] + W'(1)) : acc_q[2*W-1:W];
    assign a_raw    = sa_q ? (~a_q + W'(1)) : a_q;

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = CALC;
                    is_div_d = op[1];
                    sa_d     = op[0] & dato_A[W-1];
                    sb_d     = op[0] & dato_B[W-1];
                    a_d      = mag_a;
                    b_d      = mag_b;
                    acc_d    = op[1] ? {W'(0), mag_a} : {W'(0), mag_b};
                    cnt_d    = CW'(0);
                    busy_d   = 1'b1;
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEP - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end else if (b_q == W'(0)) begin
                    // Divide by zero: all-ones quotient, dividend passed through.
                    hi_d   = a_raw;
                    lo_d   = {W{1'b1}};
                    div0_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign div0  = div0_q;
    assign stall = busy_q | (start & ~done_q);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: a stimulus process pushes expected
// results from an arithmetic reference model; a monitor pops them on done.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] dato_A = '0;
    logic [31:0] dato_B = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div0, stall;

    ex_muldiv dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .dato_A (dato_A),
        .dato_B (dato_B),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .div0   (div0),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rst_edge = 1'b1;
    bit   armed = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model from plain integer arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        logic [63:0] p;
        longint sa, sb2, q, r;
        e.div0 = 1'b0;
        e.due  = 0;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        case (o)
            2'd0: begin
                p = 64'(a) * 64'(b);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd1: begin
                p = 64'(sa * sb2);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.div0 = 1'b1;
                end else if (o == 2'd2) begin
                    e.hi = a % b;
                    e.lo = a / b;
                end else begin
                    q = sa / sb2;
                    r = sa % sb2;
                    e.hi = 32'(r);
                    e.lo = 32'(q);
                end
            end
        endcase
        return e;
    endfunction

    // Issue one operation from an idle, non-done DUT and follow busy to done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit hold);
        exp_t e;
        int   n;
        bit   seen;
        @(posedge clk);
        #1;
        start = 1'b1;
        op = o;
        dato_A = a;
        dato_B = b;
        e = model(o, a, b);
        e.due = cyc + 34;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        n = 0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) begin
                n++;
                if (i == 0) chk("stall_while_busy", 64'(stall), 64'd1);
            end else begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=busy_stuck expected=busy_drop");
        end else begin
            chk("busy_cycles", 64'(n), 64'd33);
            chk("stall_in_done", 64'(stall), 64'd0);
        end
        if (hold) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk("single_op_busy", 64'(busy), 64'd0);
        end
    endtask

    // Monitor: results on done, quiet div0 and held hi/lo otherwise.
    initial begin
        exp_t e;
        logic [31:0] prev_hi, prev_lo;
        bit have_prev;
        have_prev = 0;
        prev_hi = '0;
        prev_lo = '0;
        wait (armed);
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done expected=no_done (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result_hi", 64'(hi), 64'(e.hi));
                    chk("result_lo", 64'(lo), 64'(e.lo));
                    chk("result_div0", 64'(div0), 64'(e.div0));
                    chk("latency", 64'(cyc), 64'(e.due));
                end
            end else begin
                chk("div0_quiet", 64'(div0), 64'd0);
                if (have_prev && !rst_edge) begin
                    chk("hold_hi", 64'(hi), 64'(prev_hi));
                    chk("hold_lo", 64'(lo), 64'(prev_lo));
                end
            end
            prev_hi = hi;
            prev_lo = lo;
            have_prev = 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_div0", 64'(div0), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        armed = 1;

        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'd2, 32'd100, 32'd0, 0);
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'd3, 32'h8000_0005, 32'd0, 0);
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'd0, 32'd3, 32'd4, 0);
        run_op(2'd2, 32'd13, 32'd4, 0);
        run_op(2'd1, 32'd6, 32'hFFFF_FFFE, 1);
        run_op(2'd3, 32'd7, 32'hFFFF_FFFE, 0);

        for (int k = 0; k < 24; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 0);
        end

        // Abort a DIVU 50/7 by reset part-way through CALC; no result expected.
        @(posedge clk);
        #1;
        start = 1'b1;
        op = 2'd2;
        dato_A = 32'd50;
        dato_B = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_stall", 64'(stall), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);

        run_op(2'd2, 32'd50, 32'd7, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
